// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker on the output side of a two-direction traffic light controller.
// Inputs are registered once; faults judged on that sample reach the outputs on the following edge.
module traffic_monitor #(
   parameter int CNT_W = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       lampa,
   input  logic [3:0]       lampb,
   input  logic [CNT_W-1:0] acount,
   input  logic [CNT_W-1:0] bcount,
   input  logic             clr,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic             fault_dir,
   output logic [ERR_W-1:0] err_cnt
);
   localparam logic [3:0] RED = 4'b1000;
   localparam logic [3:0] YEL = 4'b0100;
   localparam logic [3:0] GRN = 4'b0010;
   localparam logic [3:0] LFT = 4'b0001;

   logic             r_en_s;
   logic [3:0]       r_lampa_s;
   logic [3:0]       r_lampb_s;
   logic [CNT_W-1:0] r_acnt_s;
   logic [CNT_W-1:0] r_bcnt_s;
   logic [3:0]       r_prev_lampa;
   logic [3:0]       r_prev_lampb;
   logic [CNT_W-1:0] r_prev_acnt;
   logic [CNT_W-1:0] r_prev_bcnt;
   logic             r_armed_a;
   logic             r_armed_b;
   logic             r_ygrn_a;   // 1: the latest yellow was entered from green
   logic             r_ygrn_b;
   logic             r_fault;
   logic [2:0]       r_fault_code;
   logic             r_fault_dir;
   logic [ERR_W-1:0] r_err_cnt;

   logic [2:0]       w_code_a;
   logic [2:0]       w_code_b;
   logic [2:0]       w_code;
   logic             w_dir;
   logic             w_conflict;
   logic             w_any;

   function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] r;
      r = c;
      if (c[3:0] == 4'd0) begin
         r[3:0] = 4'd9;
         r[7:4] = c[7:4] - 4'd1;
      end else begin
         r[3:0] = c[3:0] - 4'd1;
      end
      return r;
   endfunction

   function automatic logic legal_step(input logic [3:0] from, input logic [3:0] to,
                                       input logic ygrn);
      case (from)
         GRN:     legal_step = (to == YEL);
         YEL:     legal_step = ygrn ? (to == LFT) : (to == RED);
         LFT:     legal_step = (to == YEL);
         RED:     legal_step = (to == GRN);
         default: legal_step = 1'b0;
      endcase
   endfunction

   // Lowest fault code for one direction; codes 2-4 need an armed, enabled sample.
   function automatic logic [2:0] dir_code(input logic [3:0] lamp, input logic [3:0] prev_lamp,
                                           input logic [CNT_W-1:0] cnt,
                                           input logic [CNT_W-1:0] prev_cnt,
                                           input logic chk, input logic ygrn);
      logic pc;
      logic bad_digit;
      pc        = (lamp != prev_lamp);
      bad_digit = (cnt[7:4] > 4'd9) || (cnt[3:0] > 4'd9);
      if (!$onehot(lamp))
         dir_code = 3'd1;
      else if (chk && pc && !legal_step(prev_lamp, lamp, ygrn))
         dir_code = 3'd2;
      else if (chk && (pc != (prev_cnt == CNT_W'(1))))
         dir_code = 3'd3;
      else if (chk && (bad_digit || (cnt == '0) || (!pc && (cnt != bcd_dec(prev_cnt)))))
         dir_code = 3'd4;
      else
         dir_code = 3'd0;
   endfunction

   always_comb begin
      w_code_a   = dir_code(r_lampa_s, r_prev_lampa, r_acnt_s, r_prev_acnt,
                            r_armed_a && r_en_s, r_ygrn_a);
      w_code_b   = dir_code(r_lampb_s, r_prev_lampb, r_bcnt_s, r_prev_bcnt,
                            r_armed_b && r_en_s, r_ygrn_b);
      w_conflict = r_en_s && (r_lampa_s != RED) && (r_lampb_s != RED);
      w_code     = 3'd0;
      w_dir      = 1'b0;
      if ((w_code_a != 3'd0) && ((w_code_b == 3'd0) || (w_code_a <= w_code_b))) begin
         w_code = w_code_a;
      end else if (w_code_b != 3'd0) begin
         w_code = w_code_b;
         w_dir  = 1'b1;
      end else if (w_conflict) begin
         w_code = 3'd5;
      end
      w_any = (w_code != 3'd0);
   end

   // Sample stage plus per-direction history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_s       <= 1'b0;
         r_lampa_s    <= RED;
         r_lampb_s    <= RED;
         r_acnt_s     <= '0;
         r_bcnt_s     <= '0;
         r_prev_lampa <= RED;
         r_prev_lampb <= RED;
         r_prev_acnt  <= '0;
         r_prev_bcnt  <= '0;
         r_armed_a    <= 1'b0;
         r_armed_b    <= 1'b0;
         r_ygrn_a     <= 1'b0;
         r_ygrn_b     <= 1'b0;
      end else begin
         r_en_s       <= en;
         r_lampa_s    <= lampa;
         r_lampb_s    <= lampb;
         r_acnt_s     <= acount;
         r_bcnt_s     <= bcount;
         r_prev_lampa <= r_lampa_s;
         r_prev_lampb <= r_lampb_s;
         r_prev_acnt  <= r_acnt_s;
         r_prev_bcnt  <= r_bcnt_s;
         r_armed_a    <= r_en_s && (r_armed_a || (r_lampa_s != r_prev_lampa) ||
                                    (r_acnt_s != r_prev_acnt));
         r_armed_b    <= r_en_s && (r_armed_b || (r_lampb_s != r_prev_lampb) ||
                                    (r_bcnt_s != r_prev_bcnt));
         if ((r_lampa_s == YEL) && (r_prev_lampa == GRN))
            r_ygrn_a <= 1'b1;
         else if ((r_lampa_s == YEL) && (r_prev_lampa == LFT))
            r_ygrn_a <= 1'b0;
         if ((r_lampb_s == YEL) && (r_prev_lampb == GRN))
            r_ygrn_b <= 1'b1;
         else if ((r_lampb_s == YEL) && (r_prev_lampb == LFT))
            r_ygrn_b <= 1'b0;
      end
   end

   // Sticky first-fault capture and saturating fault-cycle count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault      <= 1'b0;
         r_fault_code <= 3'd0;
         r_fault_dir  <= 1'b0;
         r_err_cnt    <= '0;
      end else if (clr) begin
         r_fault      <= w_any;
         r_fault_code <= w_code;
         r_fault_dir  <= w_dir;
         r_err_cnt    <= ERR_W'(w_any);
      end else begin
         if (w_any && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_code;
            r_fault_dir  <= w_dir;
         end
         if (w_any && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end

   assign fault      = r_fault;
   assign fault_code = r_fault_code;
   assign fault_dir  = r_fault_dir;
   assign err_cnt    = r_err_cnt;

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Passive checker that sits on the output side of the two-direction traffic light controller. It samples the lamp vectors and BCD countdowns for direction A and direction B on every clock and verifies the one-hot lamp encoding, the lamp sequence, the countdown arithmetic, phase-end timing and cross-direction conflicts. It latches the first fault for the supervisor/debug LEDs and counts faulty cycles. It never drives the controller.

## Interface
- `CNT_W`, 8 — countdown width; two BCD digits, [7:4] tens, [3:0] units.
- `ERR_W`, 8 — width of the saturating fault-cycle counter.

Ports:
- `clk`  in  1 — system clock; one sample per rising edge.
- `rst_n`  in  1 — asynchronous, active-low reset.
- `en`  in  1 — the controller enable, same signal the controller sees.
- `lampa`  in  4 — direction A lamps: 1000 red, 0100 yellow, 0010 green, 0001 left-turn.
- `lampb`  in  4 — direction B lamps, same encoding.
- `acount`  in  CNT_W — direction A BCD countdown.
- `bcount`  in  CNT_W — direction B BCD countdown.
- `clr`  in  1 — synchronous clear of the sticky fault state and `err_cnt`.
- `fault`  out  1 — sticky; set on the first detected fault.
- `fault_code`  out  3 — code of the first latched fault.
- `fault_dir`  out  1 — direction of the first latched fault: 0 = A, 1 = B. It is 0 for code 5.
- `err_cnt`  out  ERR_W — number of cycles with at least one fault; saturates.

## Operation
- Per-direction registers: `prev_lamp[3:0]`, `prev_cnt[7:0]`, `armed`. All three update every cycle.
- Arming: a direction sets `armed` in a cycle with en=1 where lamp≠prev_lamp or count≠prev_cnt. `armed` clears whenever en=0.
- Phase-change cycle (armed, lamp≠prev_lamp): the controller loads the new count in the same cycle as the lamp change.
- Fault codes, evaluated per direction each cycle:
  - 1 — lamp not exactly one-hot. Always checked, including when en=0.
  - 2 — illegal transition on a phase-change cycle. Legal: green→yellow, yellow→left, left→yellow, yellow→red, red→green. The sequence tracker records whether the previous yellow followed green or left. Yellow after green must go to left; yellow after left must go to red.
  - 3 — timing. Either the phase changed while prev_cnt≠0x01, or the lamp is unchanged while prev_cnt=0x01.
  - 4 — count. Either digit >9 or count=0x00 (armed only). On a non-phase-change armed cycle, count must equal BCD(prev_cnt−1). Example: 0x40→0x39, 0x10→0x09.
  - 5 — conflict: en=1 and neither lampa nor lampb is red.
- Codes 2–4 are checked only while armed, and never in the arming cycle itself.
- First-fault capture: when `fault`=0 and any fault occurs, latch `fault`=1 with the lowest code. Direction A beats direction B on a tie. Later faults do not change `fault_code` or `fault_dir`.
- `err_cnt` increments by 1 per cycle with any fault, whatever the number of faults that cycle. It holds at 2^ERR_W−1.
- `clr`=1: clear `fault`, `fault_code`, `fault_dir` and `err_cnt` in that edge. A fault in the same cycle is then captured as the first fault, and `err_cnt` becomes 1.
- en falling mid-phase: the controller forces red and freezes the count. The monitor disarms and checks only code 1. Sticky outputs keep their values.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - outputs: `fault`=0, `fault_code`=0, `fault_dir`=0, `err_cnt`=0.
  - internal state: `armed`=0, `prev_lamp`=1000, `prev_cnt`=0x00, sequence tracker = "after left".
- Latency: a fault on the sample at edge N is visible on `fault`/`err_cnt` after edge N+1. Outputs are registered with no combinational path from the inputs.
- Reset deassertion mid-operation: the monitor re-arms on the first observed change. No fault is raised for the controller's current phase before arming.
- Throughput: one check per clock, back-to-back. There is no handshake.

## Test plan
- **Reset/idle:** rst_n=0, then 1 with en=0, lamps 1000/1000 for 20 cycles → fault=0, err_cnt=0.
- **Clean run:** en=1 with a conforming controller model (A: green 40, yellow 5, left 15, yellow 5, red 55; B: red 65, green 30, yellow 5, left 15, yellow 5) for 3 full cycles → fault=0, err_cnt=0.
- **Bad decrement:** acount 0x40→0x38 mid-green → fault=1, code=4, dir=0, err_cnt=1 one cycle later.
- **Illegal sequence and timing:** force lampa green→red at prev_cnt=0x01 → code 2. Then clr and hold green with count 0x01 for one extra cycle → code 3.
- **Conflict and tie:** lampa=0010 and lampb=0010 together, plus lampb=0110 → first fault code 1, dir 1 (code 1 < 5). err_cnt increments once per offending cycle.
- **Saturation and clear:** hold lampa=0000 for 300 cycles with ERR_W=8 → err_cnt=255. clr with a fault still present → fault=1, code=1, err_cnt=1. Assert rst_n=0 mid-run → all outputs 0 immediately.
